// File: rtl/cp0_unit_if.sv
// cp0_unit_if: signal bundle between the M stage / device IRQ lines and CP0.
// master = CPU side (drives the request), slave = CP0 (drives read data and flush).
interface cp0_unit_if;
   logic [4:0]  addr;     // CP0 register number (mfc0/mtc0)
   logic        WE;       // mtc0 write enable
   logic [31:0] din;      // mtc0 write data
   logic [31:0] pc;       // PC of the M-stage instruction
   logic        bdIn;     // M-stage instruction sits in a delay slot
   logic [4:0]  excCode;  // internal exception code, 0 = none
   logic        exlClr;   // eret in the M stage
   logic [5:0]  hwInt;    // device interrupt lines, bit 0 = IP2
   logic [31:0] dataOut;  // combinational read data
   logic [31:0] EPCout;   // registered EPC for eret
   logic        excOut;   // flush and redirect to the handler

   modport master (
      output addr, WE, din, pc, bdIn, excCode, exlClr, hwInt,
      input  dataOut, EPCout, excOut
   );

   modport slave (
      input  addr, WE, din, pc, bdIn, excCode, exlClr, hwInt,
      output dataOut, EPCout, excOut
   );
endinterface

// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor 0 with SR, Cause, EPC and PRId. Decides interrupt/exception
// entry every cycle and supplies the eret return PC.
// Optional Count/Compare timer: define CP0_COUNT_EN to add regs 9/11 and the IP7 timer.
module cp0_unit #(
   parameter logic [31:0] PRID_VAL = 32'h4255_4141,
   parameter logic [5:0]  RESET_IM = 6'b000000
) (
   input logic       clk,
   input logic       reset,
   cp0_unit_if.slave bus
);

   localparam logic [4:0] AddrCount   = 5'd9;
   localparam logic [4:0] AddrCompare = 5'd11;
   localparam logic [4:0] AddrSr      = 5'd12;
   localparam logic [4:0] AddrCause   = 5'd13;
   localparam logic [4:0] AddrEpc     = 5'd14;
   localparam logic [4:0] AddrPrid    = 5'd15;

   // Status register fields
   logic [5:0]  r_im;
   logic        r_exl;
   logic        r_ie;

   // Cause register fields
   logic        r_bd;
   logic [5:0]  r_ip;
   logic [4:0]  r_exc_code;

   // Exception PC, bits [1:0] are only ever loaded with zero
   logic [31:0] r_epc;

   logic [5:0]  w_hw_int;
   logic        w_int_req;
   logic        w_exc_req;
   logic        w_exc_out;
   logic        w_wr_en;
   logic        w_wr_sr;
   logic        w_wr_epc;
   logic [31:0] w_epc_entry;
   logic [31:0] w_sr_rd;
   logic [31:0] w_cause_rd;
   logic [31:0] w_rd_data;

`ifdef CP0_COUNT_EN
   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic        r_timer_pend;
   logic        w_timer_hit;
   logic        w_timer_pend;
   logic        w_wr_count;
   logic        w_wr_compare;

   // The match is folded in combinationally so the interrupt is seen on the very
   // cycle Count equals Compare; the register keeps it sticky afterwards.
   assign w_timer_hit  = (r_count == r_compare) && (r_compare != 32'd0);
   assign w_timer_pend = r_timer_pend | w_timer_hit;
   assign w_hw_int     = bus.hwInt | {w_timer_pend, 5'b00000};
   assign w_wr_count   = w_wr_en && (bus.addr == AddrCount);
   assign w_wr_compare = w_wr_en && (bus.addr == AddrCompare);
`else
   assign w_hw_int = bus.hwInt;
`endif

   // Live hwInt is used (not Cause.IP) so a request is taken with zero latency.
   assign w_int_req = (|(w_hw_int & r_im)) & r_ie & ~r_exl;
   assign w_exc_req = (bus.excCode != 5'd0) & ~r_exl;
   assign w_exc_out = w_int_req | w_exc_req;

   // An mtc0 in a flushed cycle belongs to an instruction that will not retire.
   assign w_wr_en  = bus.WE & ~w_exc_out;
   assign w_wr_sr  = w_wr_en && (bus.addr == AddrSr);
   assign w_wr_epc = w_wr_en && (bus.addr == AddrEpc);

   // Delay-slot faults return to the branch so the branch is re-executed.
   assign w_epc_entry = (bus.bdIn ? (bus.pc - 32'd4) : bus.pc) & ~32'd3;

   // SR: entry sets EXL, eret clears it, mtc0 loads IM/EXL/IE
   always_ff @(posedge clk) begin
      if (reset) begin
         r_im  <= RESET_IM;
         r_exl <= 1'b0;
         r_ie  <= 1'b0;
      end else begin
         if (w_wr_sr) begin
            r_im <= bus.din[15:10];
            r_ie <= bus.din[0];
         end
         // Entry beats eret, eret beats an mtc0 to EXL in the same cycle.
         if (w_exc_out) begin
            r_exl <= 1'b1;
         end else if (bus.exlClr) begin
            r_exl <= 1'b0;
         end else if (w_wr_sr) begin
            r_exl <= bus.din[1];
         end
      end
   end

   // Cause: IP samples the interrupt lines every cycle; BD/ExcCode latch on entry
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ip       <= 6'd0;
         r_bd       <= 1'b0;
         r_exc_code <= 5'd0;
      end else begin
         r_ip <= w_hw_int;
         if (w_exc_out) begin
            r_bd       <= bus.bdIn;
            r_exc_code <= w_int_req ? 5'd0 : bus.excCode;
         end
      end
   end

   // EPC: loaded on entry, otherwise by mtc0 (word aligned)
   always_ff @(posedge clk) begin
      if (reset) begin
         r_epc <= 32'd0;
      end else if (w_exc_out) begin
         r_epc <= w_epc_entry;
      end else if (w_wr_epc) begin
         r_epc <= bus.din & ~32'd3;
      end
   end

`ifdef CP0_COUNT_EN
   // Count/Compare timer: free-running counter with sticky match pending bit
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count      <= 32'd0;
         r_compare    <= 32'd0;
         r_timer_pend <= 1'b0;
      end else begin
         if (w_wr_count) begin
            r_count <= bus.din;
         end else begin
            r_count <= r_count + 32'd1;
         end
         if (w_wr_compare) begin
            r_compare    <= bus.din;
            r_timer_pend <= 1'b0;
         end else begin
            r_timer_pend <= w_timer_pend;
         end
      end
   end
`endif

   assign w_sr_rd    = {16'd0, r_im, 8'd0, r_exl, r_ie};
   assign w_cause_rd = {r_bd, 15'd0, r_ip, 3'd0, r_exc_code, 2'd0};

   // Read mux: combinational from current register state, no write bypass
   always_comb begin
      w_rd_data = 32'd0;
      case (bus.addr)
         AddrSr:      w_rd_data = w_sr_rd;
         AddrCause:   w_rd_data = w_cause_rd;
         AddrEpc:     w_rd_data = r_epc;
         AddrPrid:    w_rd_data = PRID_VAL;
`ifdef CP0_COUNT_EN
         AddrCount:   w_rd_data = r_count;
         AddrCompare: w_rd_data = r_compare;
`endif
         default:     w_rd_data = 32'd0;
      endcase
   end

   assign bus.dataOut = w_rd_data;
   assign bus.EPCout  = r_epc;
   assign bus.excOut  = w_exc_out;

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed test-plan steps followed by a random phase, all checked
// against a register-image model of CP0 kept in this bench.
module tb_cp0_unit;

   localparam logic [31:0] PRID = 32'h4255_4141;
   localparam logic [5:0]  RIM  = 6'b000000;

   logic clk = 1'b0;
   logic t_reset;

   logic [4:0]  t_addr;
   logic        t_we;
   logic [31:0] t_din;
   logic [31:0] t_pc;
   logic        t_bd;
   logic [4:0]  t_exc;
   logic        t_eret;
   logic [5:0]  t_hw;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: architectural register images
   logic [31:0] m_sr, m_cause, m_epc, m_count, m_compare;
   logic        m_pend;

   cp0_unit_if bus_if ();

   assign bus_if.addr    = t_addr;
   assign bus_if.WE      = t_we;
   assign bus_if.din     = t_din;
   assign bus_if.pc      = t_pc;
   assign bus_if.bdIn    = t_bd;
   assign bus_if.excCode = t_exc;
   assign bus_if.exlClr  = t_eret;
   assign bus_if.hwInt   = t_hw;

   cp0_unit #(
      .PRID_VAL (PRID),
      .RESET_IM (RIM)
   ) dut (
      .clk   (clk),
      .reset (t_reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   function automatic logic m_timer();
`ifdef CP0_COUNT_EN
      return m_pend || ((m_count == m_compare) && (m_compare != 32'd0));
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [5:0] m_hw();
      return t_hw | {m_timer(), 5'b00000};
   endfunction

   function automatic logic m_int();
      return (|(m_hw() & m_sr[15:10])) && m_sr[0] && !m_sr[1];
   endfunction

   function automatic logic m_exc();
      return (t_exc != 5'd0) && !m_sr[1];
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return PRID;
`ifdef CP0_COUNT_EN
         5'd9:    return m_count;
         5'd11:   return m_compare;
`endif
         default: return 32'd0;
      endcase
   endfunction

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic m_step();
      logic        take, intr, pend_n;
      logic [5:0]  hw;
      logic [31:0] sr_n, cause_n, epc_n, cnt_n, cmp_n;
      if (t_reset) begin
         m_sr      = {16'd0, RIM, 10'd0};
         m_cause   = 32'd0;
         m_epc     = 32'd0;
         m_count   = 32'd0;
         m_compare = 32'd0;
         m_pend    = 1'b0;
         return;
      end
      intr   = m_int();
      take   = intr || m_exc();
      hw     = m_hw();
      sr_n   = m_sr;
      epc_n  = m_epc;
      cnt_n  = m_count + 32'd1;
      cmp_n  = m_compare;
      pend_n = m_timer();
      cause_n = {m_cause[31], 15'd0, hw, 3'd0, m_cause[6:2], 2'd0};
      if (take) begin
         sr_n[1] = 1'b1;
         cause_n = {t_bd, 15'd0, hw, 3'd0, (intr ? 5'd0 : t_exc), 2'd0};
         epc_n   = (t_bd ? t_pc - 32'd4 : t_pc) & ~32'd3;
      end else begin
         if (t_we) begin
            case (t_addr)
               5'd9:    cnt_n = t_din;
               5'd11:   begin cmp_n = t_din; pend_n = 1'b0; end
               5'd12:   sr_n = t_din & 32'h0000_FC03;
               5'd14:   epc_n = t_din & ~32'd3;
               default: ;
            endcase
         end
         if (t_eret) sr_n[1] = 1'b0;
      end
      m_sr      = sr_n;
      m_cause   = cause_n;
      m_epc     = epc_n;
      m_count   = cnt_n;
      m_compare = cmp_n;
      m_pend    = pend_n;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      t_addr = 5'd0;
      t_we   = 1'b0;
      t_din  = 32'd0;
      t_pc   = 32'd0;
      t_bd   = 1'b0;
      t_exc  = 5'd0;
      t_eret = 1'b0;
      t_hw   = 6'd0;
   endtask

   // Called just after a negedge with inputs applied; checks outputs, then clocks.
   task automatic step_cycle();
      #1;
      chk("dataOut", bus_if.dataOut, m_read(t_addr));
      chk("excOut", {31'd0, bus_if.excOut}, {31'd0, (m_int() || m_exc())});
      chk("EPCout", bus_if.EPCout, m_epc);
      @(posedge clk);
      m_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle();
      t_reset = 1'b1;
      @(posedge clk);
      m_step();
      @(negedge clk);
      t_reset = 1'b0;
   endtask

   logic [4:0] addr_tab [10] = '{5'd9, 5'd11, 5'd12, 5'd12, 5'd13, 5'd14, 5'd14, 5'd15,
                                 5'd0, 5'd31};

   initial begin
      idle();
      t_reset = 1'b1;
      @(negedge clk);
      do_reset();

      // Reset state
      t_addr = 5'd12; #1 chk("rst_sr", bus_if.dataOut, {16'd0, RIM, 10'd0}); step_cycle();
      t_addr = 5'd13; #1 chk("rst_cause", bus_if.dataOut, 32'd0); step_cycle();
      t_addr = 5'd15; #1 chk("prid", bus_if.dataOut, PRID); step_cycle();

      // Interrupt entry
      idle(); t_we = 1'b1; t_addr = 5'd12; t_din = 32'h0000_0401; step_cycle();
      idle(); t_hw = 6'b000001; t_pc = 32'h3008;
      #1 chk("int_excOut", {31'd0, bus_if.excOut}, 32'd1); step_cycle();
      idle(); t_hw = 6'b000001; t_addr = 5'd14;
      #1 chk("int_epc", bus_if.dataOut, 32'h0000_3008); step_cycle();
      idle(); t_hw = 6'b000001; t_addr = 5'd13;
      #1 chk("int_cause", bus_if.dataOut, 32'h0000_0400); step_cycle();
      idle(); t_hw = 6'b000001; t_addr = 5'd12;
      #1 chk("int_sr_exl", bus_if.dataOut, 32'h0000_0403); step_cycle();
      idle(); t_eret = 1'b1; step_cycle();

      // Delay-slot exception then eret
      idle(); t_exc = 5'd4; t_bd = 1'b1; t_pc = 32'h3010;
      #1 chk("bd_excOut", {31'd0, bus_if.excOut}, 32'd1); step_cycle();
      idle(); t_addr = 5'd14; #1 chk("bd_epc", bus_if.dataOut, 32'h0000_300C); step_cycle();
      idle(); t_addr = 5'd13; #1 chk("bd_cause", bus_if.dataOut, 32'h8000_0010); step_cycle();
      idle(); t_eret = 1'b1; step_cycle();
      idle(); t_addr = 5'd12; #1 chk("eret_sr", bus_if.dataOut, 32'h0000_0401); step_cycle();

      // Masking by EXL, then by IE
      idle(); t_we = 1'b1; t_addr = 5'd12; t_din = 32'h0000_FC03; step_cycle();
      idle(); t_hw = 6'h3F; #1 chk("mask_exl", {31'd0, bus_if.excOut}, 32'd0); step_cycle();
      idle(); t_hw = 6'h3F; t_addr = 5'd13;
      #1 chk("mask_ip", {26'd0, bus_if.dataOut[15:10]}, 32'h3F); step_cycle();
      idle(); t_hw = 6'h3F; t_we = 1'b1; t_addr = 5'd12; t_din = 32'h0000_FC00; step_cycle();
      idle(); t_hw = 6'h3F; #1 chk("mask_ie", {31'd0, bus_if.excOut}, 32'd0); step_cycle();

      // Priority and mtc0 collision
      idle(); t_we = 1'b1; t_addr = 5'd12; t_din = 32'h0000_0401; step_cycle();
      idle(); t_hw = 6'b000001; t_exc = 5'd10; t_we = 1'b1; t_addr = 5'd14;
      t_din = 32'h0000_1234; t_pc = 32'h4000;
      #1 chk("prio_excOut", {31'd0, bus_if.excOut}, 32'd1); step_cycle();
      idle(); t_addr = 5'd14; #1 chk("prio_epc", bus_if.dataOut, 32'h0000_4000); step_cycle();
      idle(); t_addr = 5'd13; #1 chk("prio_cause", bus_if.dataOut, 32'd0); step_cycle();

      // Register access
      idle(); t_eret = 1'b1; step_cycle();
      idle(); t_we = 1'b1; t_addr = 5'd14; t_din = 32'h0000_3007;
      #1 chk("rd_old", bus_if.dataOut, 32'h0000_4000); step_cycle();
      idle(); t_addr = 5'd14; #1 chk("epc_align", bus_if.dataOut, 32'h0000_3004);
      chk("epcout", bus_if.EPCout, 32'h0000_3004); step_cycle();
      idle(); t_we = 1'b1; t_addr = 5'd13; t_din = 32'hFFFF_FFFF; step_cycle();
      idle(); t_addr = 5'd13; #1 chk("cause_ro", bus_if.dataOut, 32'd0); step_cycle();
      idle(); t_we = 1'b1; t_addr = 5'd15; t_din = 32'd0; step_cycle();
      idle(); t_addr = 5'd15; #1 chk("prid_ro", bus_if.dataOut, PRID); step_cycle();
      idle(); t_we = 1'b1; t_addr = 5'd5; t_din = 32'hDEAD_BEEF; step_cycle();
      idle(); t_addr = 5'd5; #1 chk("unmapped", bus_if.dataOut, 32'd0); step_cycle();
      do_reset();
      idle(); t_addr = 5'd12; #1 chk("rst2_sr", bus_if.dataOut, 32'd0); step_cycle();
      idle(); t_addr = 5'd14; #1 chk("rst2_epc", bus_if.dataOut, 32'd0);
      chk("rst2_epcout", bus_if.EPCout, 32'd0); step_cycle();

`ifdef CP0_COUNT_EN
      // Timer interrupt on Count == Compare
      idle(); t_we = 1'b1; t_addr = 5'd11; t_din = 32'd5; step_cycle();
      idle(); t_we = 1'b1; t_addr = 5'd9; t_din = 32'd0; step_cycle();
      idle(); t_we = 1'b1; t_addr = 5'd12; t_din = 32'h0000_8001; step_cycle();
      for (int i = 0; i < 4; i++) begin
         idle(); t_addr = 5'd9; step_cycle();
      end
      idle(); t_addr = 5'd9;
      #1 chk("tmr_count", bus_if.dataOut, 32'd5);
      chk("tmr_excOut", {31'd0, bus_if.excOut}, 32'd1); step_cycle();
      idle(); t_we = 1'b1; t_addr = 5'd11; t_din = 32'h0000_1000; step_cycle();
      idle(); t_eret = 1'b1; step_cycle();
      idle(); #1 chk("tmr_clear", {31'd0, bus_if.excOut}, 32'd0); step_cycle();
`endif

      // Random phase
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            do_reset();
         end else begin
            idle();
            t_addr = addr_tab[$urandom_range(0, 9)];
            t_we   = ($urandom_range(0, 2) == 0);
            t_din  = $urandom;
            if ($urandom_range(0, 1) == 0) t_din[0] = 1'b1;
            t_pc   = $urandom;
            t_bd   = 1'($urandom);
            t_exc  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'd0;
            t_eret = ($urandom_range(0, 3) == 0);
            t_hw   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            step_cycle();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
